// File: rtl/simple_io_responder.sv
// simple_io_responder
//   Peripheral end of the CPU IN/OUT instruction interface.
//   OUT writes are queued in a TX FIFO that drains to an external sink
//   through valid/ready. Words from an external source are queued in an RX
//   FIFO and handed back to the CPU one per IN instruction. A combinational
//   stall holds the CPU whenever a request cannot be serviced this cycle.
//
//   Build option: define IO_LOOPBACK_EN to route the TX head straight into
//   the RX FIFO. The external ports are then idle: ext_out_valid and
//   ext_in_ready stay 0, and ext_out_ready/ext_in_* are ignored.
//
// Parameters
//   WIDTH : data word width
//   AW    : log2 of FIFO depth (each FIFO holds 2**AW words)
//
// Ports
//   clk, rst_n              : clock, synchronous active-low reset
//   out_req, out_data       : CPU OUT strobe and word
//   in_req                  : CPU IN strobe
//   in_data, in_valid       : word returned to the CPU, one-cycle valid pulse
//   stall                   : CPU must hold its current instruction
//   ext_out_data/valid/ready: TX FIFO head towards the external sink
//   ext_in_data/valid/ready : external source into the RX FIFO
//   tx_count, rx_count      : FIFO occupancies
module simple_io_responder #(
  parameter int WIDTH = 16,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             out_req,
  input  logic [WIDTH-1:0] out_data,
  input  logic             in_req,
  output logic [WIDTH-1:0] in_data,
  output logic             in_valid,
  output logic             stall,
  output logic [WIDTH-1:0] ext_out_data,
  output logic             ext_out_valid,
  input  logic             ext_out_ready,
  input  logic [WIDTH-1:0] ext_in_data,
  input  logic             ext_in_valid,
  output logic             ext_in_ready,
  output logic [AW:0]      tx_count,
  output logic [AW:0]      rx_count
);

  localparam int          DEPTH = 1 << AW;
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] tx_mem [DEPTH];
  logic [WIDTH-1:0] rx_mem [DEPTH];
  logic [AW-1:0]    tx_wr, tx_rd, rx_wr, rx_rd;
  logic [AW:0]      tx_cnt, rx_cnt;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic             tx_push, tx_pop, rx_push, rx_pop;
  logic [WIDTH-1:0] rx_wdata;

  assign tx_full  = (tx_cnt == FULL);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL);
  assign rx_empty = (rx_cnt == '0);

  assign ext_out_data = tx_mem[tx_rd];

`ifdef IO_LOOPBACK_EN
  // TX head moves into RX whenever there is room; external side is parked.
  logic unused_loop;
  assign unused_loop   = ^{ext_out_ready, ext_in_valid, ext_in_data};
  assign tx_pop        = ~tx_empty & ~rx_full;
  assign rx_push       = tx_pop;
  assign rx_wdata      = tx_mem[tx_rd];
  assign ext_out_valid = 1'b0;
  assign ext_in_ready  = 1'b0;
`else
  assign ext_out_valid = ~tx_empty;
  assign tx_pop        = ext_out_valid & ext_out_ready;
  assign ext_in_ready  = ~rx_full;
  assign rx_push       = ext_in_valid & ext_in_ready;
  assign rx_wdata      = ext_in_data;
`endif

  // A full TX is not a stall if its head leaves on this same edge. An IN
  // whose word was just returned (in_valid) is already satisfied.
  assign stall   = (out_req & tx_full & ~tx_pop)
                 | (in_req & rx_empty & ~in_valid);
  assign tx_push = out_req & ~stall;
  assign rx_pop  = in_req & ~rx_empty & ~in_valid;

  assign tx_count = tx_cnt;
  assign rx_count = rx_cnt;

  // Storage: no reset, contents are meaningless once pointers clear.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= out_data;
    if (rx_push) rx_mem[rx_wr] <= rx_wdata;
  end

  // Control: pointers, occupancies and the IN return register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_cnt   <= '0;
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_cnt   <= '0;
      in_data  <= '0;
      in_valid <= 1'b0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + AW'(1);
      tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
      if (rx_push) rx_wr <= rx_wr + AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + AW'(1);
      rx_cnt <= rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
      in_valid <= rx_pop;
      if (rx_pop) in_data <= rx_mem[rx_rd];
    end
  end

endmodule

// File: tb/tb_simple_io_responder.sv
module tb_simple_io_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        out_req;
  logic [15:0] out_data;
  logic        in_req;
  logic [15:0] in_data;
  logic        in_valid;
  logic        stall;
  logic [15:0] ext_out_data;
  logic        ext_out_valid;
  logic        ext_out_ready;
  logic [15:0] ext_in_data;
  logic        ext_in_valid;
  logic        ext_in_ready;
  logic [2:0]  tx_count;
  logic [2:0]  rx_count;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  simple_io_responder #(.WIDTH(16), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .out_req(out_req), .out_data(out_data),
    .in_req(in_req), .in_data(in_data), .in_valid(in_valid),
    .stall(stall),
    .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid),
    .ext_out_ready(ext_out_ready),
    .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid),
    .ext_in_ready(ext_in_ready),
    .tx_count(tx_count), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: two word queues plus the IN return register.
  logic [15:0] tq[$];
  logic [15:0] rq[$];
  bit          iv_m = 1'b0;
  logic [15:0] id_m = '0;

  always begin : compare
    int  txn, rxn;
    bit  eov, eir, est, tpop, tpush, rpush, rpop, rst_s;
    logic [15:0] rdat, odat;
    @(negedge clk);
    #2;
    txn = tq.size();
    rxn = rq.size();
`ifdef IO_LOOPBACK_EN
    eov   = 1'b0;
    eir   = 1'b0;
    tpop  = (txn != 0) && (rxn != 4);
    rpush = tpop;
    rdat  = tpop ? tq[0] : 16'h0;
`else
    eov   = (txn != 0);
    eir   = (rxn != 4);
    tpop  = eov && ext_out_ready;
    rpush = ext_in_valid && eir;
    rdat  = ext_in_data;
`endif
    est   = (out_req && txn == 4 && !tpop) || (in_req && rxn == 0 && !iv_m);
    tpush = out_req && !est;
    rpop  = in_req && rxn != 0 && !iv_m;
    odat  = out_data;
    rst_s = !rst_n;
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(est));
      chk("ext_out_valid", 32'(ext_out_valid), 32'(eov));
      chk("ext_in_ready", 32'(ext_in_ready), 32'(eir));
      chk("tx_count", 32'(tx_count), 32'(txn));
      chk("rx_count", 32'(rx_count), 32'(rxn));
      chk("in_valid", 32'(in_valid), 32'(iv_m));
      chk("in_data", 32'(in_data), 32'(id_m));
      if (eov) chk("ext_out_data", 32'(ext_out_data), 32'(tq[0]));
    end
    @(posedge clk);
    if (rst_s) begin
      tq.delete();
      rq.delete();
      iv_m = 1'b0;
      id_m = '0;
    end else begin
      if (rpop) id_m = rq.pop_front();
      iv_m = rpop;
      if (tpop) void'(tq.pop_front());
      if (tpush) tq.push_back(odat);
      if (rpush) rq.push_back(rdat);
    end
  end

  task automatic idle();
    out_req = 0; in_req = 0; ext_out_ready = 0; ext_in_valid = 0;
  endtask

  initial begin
    bit last_stall, last_iv, last_ir;
    logic [15:0] exp_d [4];

    // Reset with junk on the inputs.
    rst_n = 0;
    out_req = 1; out_data = 16'hDEAD; in_req = 1; ext_out_ready = 1;
    ext_in_valid = 1; ext_in_data = 16'hBAD0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    out_data = 16'h1234; ext_in_data = 16'h4321;
    @(negedge clk);
    rst_n = 1; idle();
    #4;
    chk("rst tx_count", 32'(tx_count), 0);
    chk("rst rx_count", 32'(rx_count), 0);
    chk("rst ext_out_valid", 32'(ext_out_valid), 0);
`ifndef IO_LOOPBACK_EN
    chk("rst ext_in_ready", 32'(ext_in_ready), 1);
`endif
    chk("rst stall", 32'(stall), 0);

`ifndef IO_LOOPBACK_EN
    // TX fill, full-with-simultaneous-pop, drain order.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      out_req = 1; out_data = 16'h1111 * 16'(k + 1);
    end
    @(negedge clk);
    out_data = 16'h5555;
    #4;
    chk("tx full count", 32'(tx_count), 4);
    chk("tx full stall", 32'(stall), 1);
    @(negedge clk);
    ext_out_ready = 1;
    #4;
    chk("tx swap stall", 32'(stall), 0);
    chk("tx swap head", 32'(ext_out_data), 32'h1111);
    @(negedge clk);
    out_req = 0; ext_out_ready = 0;
    #4;
    chk("tx swap count", 32'(tx_count), 4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ext_out_ready = 1;
      #4;
      chk("tx drain", 32'(ext_out_data), 32'h2222 * 32'(k + 1) - 32'h1111 * 32'(k));
    end
    @(negedge clk);
    ext_out_ready = 0;
    #4;
    chk("tx drained", 32'(tx_count), 0);

    // IN on empty RX stalls until a word arrives.
    @(negedge clk);
    in_req = 1;
    #4;
    chk("rx empty stall", 32'(stall), 1);
    @(negedge clk);
    ext_in_valid = 1; ext_in_data = 16'hBEEF;
    #4;
    chk("rx arrive stall", 32'(stall), 1);
    @(negedge clk);
    ext_in_valid = 0;
    #4;
    chk("rx ne count", 32'(rx_count), 1);
    chk("rx ne stall", 32'(stall), 0);
    @(negedge clk);
    #4;
    chk("rx beef data", 32'(in_data), 32'hBEEF);
    chk("rx beef valid", 32'(in_valid), 1);
    chk("rx beef count", 32'(rx_count), 0);
    @(negedge clk);
    in_req = 0;

    // RX full back-pressure and pointer wrap over three rounds.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        ext_in_valid = 1; ext_in_data = 16'h1000 * 16'(r + 1) + 16'(k);
      end
      @(negedge clk);
      ext_in_data = 16'hA000 + 16'(r);
      #4;
      chk("rx full ready", 32'(ext_in_ready), 0);
      @(negedge clk);
      #4;
      chk("rx held count", 32'(rx_count), 4);
      @(negedge clk);
      in_req = 1;
      @(negedge clk);
      in_req = 0;
      #4;
      chk("rx pop data", 32'(in_data), 32'(16'h1000 * 16'(r + 1)));
      chk("rx pop ready", 32'(ext_in_ready), 1);
      @(negedge clk);
      ext_in_valid = 0;
      #4;
      chk("rx refill count", 32'(rx_count), 4);
      exp_d[0] = 16'h1000 * 16'(r + 1) + 16'd1;
      exp_d[1] = 16'h1000 * 16'(r + 1) + 16'd2;
      exp_d[2] = 16'h1000 * 16'(r + 1) + 16'd3;
      exp_d[3] = 16'hA000 + 16'(r);
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        in_req = 1;
        @(negedge clk);
        in_req = 0;
        #4;
        chk("rx drain data", 32'(in_data), 32'(exp_d[j]));
      end
    end

    // Reset in the middle of a TX drain.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_req = 1; out_data = 16'hC000 + 16'(k);
    end
    @(negedge clk);
    out_req = 0; ext_out_ready = 1; rst_n = 0;
    #4;
    chk("mid tx_count", 32'(tx_count), 3);
    @(negedge clk);
    rst_n = 1; ext_out_ready = 0;
    #4;
    chk("mid rst valid", 32'(ext_out_valid), 0);
    chk("mid rst count", 32'(tx_count), 0);
`else
    // Loopback: OUT at t is readable by IN from t+2.
    @(negedge clk);
    out_req = 1; out_data = 16'h00A5;
    @(negedge clk);
    out_req = 0;
    #4;
    chk("lb ext_out_valid", 32'(ext_out_valid), 0);
    @(negedge clk);
    in_req = 1;
    #4;
    chk("lb stall", 32'(stall), 0);
    chk("lb rx_count", 32'(rx_count), 1);
    @(negedge clk);
    in_req = 0;
    #4;
    chk("lb in_data", 32'(in_data), 32'h00A5);
    chk("lb in_valid", 32'(in_valid), 1);
    chk("lb ext_out_valid2", 32'(ext_out_valid), 0);
`endif

    // Randomised CPU and external traffic; the compare process checks each cycle.
    @(negedge clk);
    idle();
    last_stall = 0; last_iv = 0; last_ir = 1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 499) != 0);
      if (!(out_req && last_stall)) begin
        out_req  = ($urandom_range(0, 2) == 0);
        out_data = 16'($urandom);
      end
      if (in_req && last_iv) in_req = 0;
      else if (!in_req) in_req = ($urandom_range(0, 2) == 0);
      if (!(ext_in_valid && !last_ir)) begin
        ext_in_valid = $urandom_range(0, 1) == 1;
        ext_in_data  = 16'($urandom);
      end
      ext_out_ready = ($urandom_range(0, 2) != 0);
      #3;
      last_stall = stall; last_iv = in_valid; last_ir = ext_in_ready;
    end
    @(negedge clk);
    rst_n = 1; idle();
    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
